// File: rtl/svc_rv_status_pkg.sv
// Shared types for the SoC status LED stage: FSM state encoding and idle
// counter sizing helper.
package svc_rv_status_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HUNG = 2'b01,
    DONE = 2'b10
  } status_state_t;

  // A disabled watchdog still gets a 1-bit counter so the port map stays uniform.
  function automatic int idle_width(input int unsigned wdt_cycles);
    return (wdt_cycles == 0) ? 1 : $clog2(wdt_cycles + 1);
  endfunction

endpackage

// File: rtl/svc_rv_status_wdt.sv
// Retire-activity watchdog: counts idle cycles, saturating at WDT_CYCLES,
// and flags expiry while the count sits at the limit.
module svc_rv_status_wdt
  import svc_rv_status_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 32'd67108864
) (
  input  logic clk,
  input  logic rst_n,
  input  logic activity,
  output logic expired
);

  localparam int IW = idle_width(WDT_CYCLES);
  localparam logic [IW-1:0] LIMIT = IW'(WDT_CYCLES);
  localparam logic WDT_ON = (WDT_CYCLES != 0);

  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (activity || !WDT_ON) begin
      idle_cnt <= '0;
    end else if (idle_cnt != LIMIT) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign expired = WDT_ON && (idle_cnt == LIMIT);

endmodule

// File: rtl/svc_rv_status_led.sv
// Board status LED: slow heartbeat while running, fast blink when the
// watchdog trips, solid on once the core hits EBREAK.
module svc_rv_status_led
  import svc_rv_status_pkg::*;
#(
  parameter int          HB_BITS    = 24,
  parameter int unsigned WDT_CYCLES = 32'd67108864
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ebreak,
  input  logic activity,
  output logic led,
  output logic done,
  output logic hung
);

  status_state_t      state;
  logic [HB_BITS-1:0] hb_cnt;
  logic               expired;

  svc_rv_status_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .activity (activity),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb_cnt <= '0;
    else        hb_cnt <= hb_cnt + HB_BITS'(1);
  end

  // LED is chosen from the current state, so it lags a transition by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      led   <= 1'b0;
    end else begin
      unique case (state)
        RUN:     led <= hb_cnt[HB_BITS-1];
        HUNG:    led <= hb_cnt[HB_BITS-3];
        DONE:    led <= 1'b1;
        default: led <= 1'b0;
      endcase

      if (ebreak) begin
        state <= DONE;
      end else begin
        unique case (state)
          RUN:     if (expired && !activity) state <= HUNG;
          HUNG:    if (activity) state <= RUN;
          DONE:    state <= DONE;
          default: state <= RUN;
        endcase
      end
    end
  end

  assign done = (state == DONE);
  assign hung = (state == HUNG);

endmodule

// File: tb/tb_svc_rv_status_led.sv
// Scoreboard bench for svc_rv_status_led: two instances (watchdog 8 and
// watchdog off) share stimulus; a reference model predicts every cycle.
module tb_svc_rv_status_led;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ebreak = 1'b0;
  logic       activity = 1'b0;
  logic [1:0] led, done, hung;

  always #5 clk = ~clk;

  svc_rv_status_led #(.HB_BITS(4), .WDT_CYCLES(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ebreak(ebreak), .activity(activity),
    .led(led[0]), .done(done[0]), .hung(hung[0])
  );

  svc_rv_status_led #(.HB_BITS(4), .WDT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ebreak(ebreak), .activity(activity),
    .led(led[1]), .done(done[1]), .hung(hung[1])
  );

  typedef struct packed {
    logic led;
    logic done;
    logic hung;
  } obs_t;

  localparam int M_RUN  = 0;
  localparam int M_HUNG = 1;
  localparam int M_DONE = 2;

  obs_t exp_q[2][$];
  int   compared   = 0;
  int   mismatched = 0;

  int m_mode[2];
  int m_t[2];
  int m_idle[2];

  function automatic int wdt_of(input int i);
    return (i == 0) ? 8 : 0;
  endfunction

  task automatic check_bit(input string name, input int i, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s dut%0d t=%0t: got %b, expected %b", name, i, $time, act, req);
    end
  endtask

  task automatic check_obs(input string tag, input int i, input obs_t e);
    check_bit({tag, "_led"},  i, led[i],  e.led);
    check_bit({tag, "_done"}, i, done[i], e.done);
    check_bit({tag, "_hung"}, i, hung[i], e.hung);
  endtask

  // Reference model: t counts edges since reset release, so the heartbeat
  // value is just t mod 16; idle is cycles since the last activity, capped.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_mode[i] = M_RUN;
        m_t[i]    = 0;
        m_idle[i] = 0;
      end else begin
        obs_t e;
        int   w;
        int   nxt;
        w = wdt_of(i);
        if (m_mode[i] == M_DONE)      e.led = 1'b1;
        else if (m_mode[i] == M_HUNG) e.led = ((m_t[i] / 2) % 2) == 1;
        else                          e.led = ((m_t[i] / 8) % 2) == 1;
        nxt = m_mode[i];
        if (ebreak)                                   nxt = M_DONE;
        else if (m_mode[i] == M_RUN && w != 0 && !activity && m_idle[i] == w) nxt = M_HUNG;
        else if (m_mode[i] == M_HUNG && activity)     nxt = M_RUN;
        m_mode[i] = nxt;
        if (w == 0 || activity)  m_idle[i] = 0;
        else if (m_idle[i] < w)  m_idle[i] = m_idle[i] + 1;
        m_t[i]  = m_t[i] + 1;
        e.done = (nxt == M_DONE);
        e.hung = (nxt == M_HUNG);
        exp_q[i].push_back(e);
      end
    end
  end

  // Monitor: outputs are presented every cycle; sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        exp_q[i].delete();
        check_obs("in_rst", i, '0);
      end else if (exp_q[i].size() > 0) begin
        check_obs("cycle", i, exp_q[i].pop_front());
      end
    end
  end

  task automatic cycle(input logic e, input logic a);
    ebreak   = e;
    activity = a;
    @(posedge clk);
    #1;
  endtask

  // Drop reset between edges and confirm the outputs clear before any edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check_obs("async_rst", i, '0);
    ebreak   = 1'b0;
    activity = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Heartbeat / watchdog expiry with no activity, then recover.
    for (int n = 1; n <= 200; n++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    for (int n = 0; n < 30; n++) cycle(1'b0, 1'b0);

    // Activity every 8th cycle keeps alive; every 10th lets it trip.
    do_reset();
    for (int n = 1; n <= 100; n++) cycle(1'b0, (n % 8) == 0);
    for (int n = 1; n <= 100; n++) cycle(1'b0, (n % 10) == 0);

    // Single-cycle EBREAK at edge 20, then random activity.
    do_reset();
    for (int n = 1; n <= 120; n++) cycle(n == 20, (n > 20) ? 1'($urandom_range(0, 1)) : 1'b0);

    // EBREAK exactly on the watchdog expiry edge.
    do_reset();
    for (int n = 1; n <= 30; n++) cycle(n == 9, 1'b0);

    // EBREAK and activity together while hung.
    do_reset();
    for (int n = 1; n <= 12; n++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    for (int n = 0; n < 10; n++) cycle(1'b0, 1'b0);

    // Random traffic with periodic mid-run resets.
    for (int seg = 0; seg < 10; seg++) begin
      do_reset();
      for (int n = 0; n < 300; n++)
        cycle($urandom_range(0, 399) == 0, $urandom_range(0, 11) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/svc_rv_status_led.md
# svc_rv_status_led

Status indicator stage that consumes the RISC-V SoC's `ebreak` and retire-activity outputs and drives a single board LED. It shows a slow heartbeat while the core runs, fast blink when a watchdog sees no retirement activity, and solid on once EBREAK is reached. It sits between the SoC instance and the board pin in every demo top, replacing ad-hoc registered-ebreak logic.

## Interface
- `HB_BITS`, default 24: heartbeat counter width; slow blink period is 2^HB_BITS cycles. Must be ≥ 4.
- `WDT_CYCLES`, default 2^26: cycles without `activity` before HUNG is declared; 0 disables the watchdog.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ebreak`  in  1  SoC EBREAK indication; level or single-cycle pulse, sampled every cycle.
- `activity`  in  1  instruction-retire strobe from the SoC; any high cycle counts as activity.
- `led`  out  1  registered LED drive, active-high.
- `done`  out  1  high while state is DONE.
- `hung`  out  1  high while state is HUNG.

## Operation
- States: RUN, HUNG, DONE. Reset state RUN.
- Heartbeat counter `hb_cnt[HB_BITS-1:0]`: free-running, increments every cycle in every state, wraps to 0; reset 0.
- Idle counter `idle_cnt`, width $clog2(WDT_CYCLES+1): cleared to 0 on any cycle with `activity`=1; otherwise increments, saturating at WDT_CYCLES; reset 0. Held at 0 when WDT_CYCLES=0.
- Transitions, evaluated each edge, priority top-down:
  - any state, `ebreak`=1 → DONE.
  - DONE → DONE (sticky until reset; `activity` and watchdog ignored).
  - RUN, WDT_CYCLES≠0, `activity`=0, `idle_cnt`=WDT_CYCLES → HUNG.
  - HUNG, `activity`=1 → RUN (and `idle_cnt` clears same edge).
  - otherwise hold.
- LED function (registered): RUN → `hb_cnt[HB_BITS-1]`; HUNG → `hb_cnt[HB_BITS-3]` (4× rate); DONE → 1.
- `done` = (state==DONE), `hung` = (state==HUNG), decoded directly from the state register (no extra delay).

## Timing
- Reset values: `led`=0, `done`=0, `hung`=0, state RUN, both counters 0. Assertion of `rst_n` takes effect immediately regardless of clock; mid-operation reset from any state returns all of the above.
- `ebreak` high at edge k → `done`=1 after edge k, `led`=1 after edge k+1 (one cycle LED latency from state).
- Watchdog: with `activity` low from reset release (first edge = edge 1), `idle_cnt` reaches WDT_CYCLES after edge WDT_CYCLES, `hung`=1 after edge WDT_CYCLES+1.
- `activity` and watchdog expiry in the same cycle: activity wins, no HUNG entry.
- `ebreak` and watchdog expiry in the same cycle: DONE wins; `hung` never asserts.
- `ebreak` and `activity` in HUNG same cycle: DONE.
- `led` in RUN/HUNG follows the selected counter bit with one cycle delay; no glitch on state change beyond that one-cycle lag.

## Structure
- Package `svc_rv_status_pkg`: `status_state_t` enum (RUN, HUNG, DONE), encoding 2'b00/2'b01/2'b10.
- One sub-module: `svc_rv_status_wdt` (idle counter + saturating compare, outputs `expired`), parameterised by WDT_CYCLES; everything else stays in the top module.
- Demo tops instantiate this block fed by `svc_init`'s `rst_n` and the SoC's `ebreak`/retire strobe, and wire `led` to `LED1`.

## Test plan
- Reset: `rst_n` low mid-run with HB_BITS=4 → `led`,`done`,`hung` 0 asynchronously, before the next edge; counters read 0 after release.
- Heartbeat: HB_BITS=4, WDT_CYCLES=0, `activity`=0 → `led` toggles every 8 cycles, period 16, `hung` never asserts over 200 cycles.
- Watchdog: HB_BITS=4, WDT_CYCLES=8, `activity`=0 from release → `hung`=1 after edge 9, `led` toggles every 2 cycles; pulse `activity` → `hung`=0 next edge, RUN.
- Activity keeps alive: WDT_CYCLES=8, `activity` pulsed every 8th cycle for 100 cycles → `hung` stays 0; pulse every 10th → `hung` asserts.
- EBREAK: single-cycle `ebreak` at edge 20 → `done`=1 after edge 20, `led`=1 from edge 21 on, stays 1 for 100 cycles despite `activity` toggling and no further `ebreak`.
- Simultaneous: `ebreak` on the exact expiry edge (edge 9, WDT_CYCLES=8) → `done`=1, `hung`=0 throughout.
